reg_file_sb: RTL and testbench

- Parametrised multi-write-port register file for the datapath. Successor to the fixed 16x8 single-write-port register file.
- Two write ports:
  - Port A: ALU write-back.
  - Port B: load-return write-back.
- Per-register scoreboard (busy) bits track outstanding loads so decode can stall on RAW hazards.
- A sequenced soft-clear engine zeroes the file without asserting reset.

---
 rtl/reg_file_pkg.sv | 27 ++
 rtl/reg_file_scoreboard.sv | 41 ++++
 rtl/reg_file_sb.sv | 134 +++++++++++++
 tb/tb_reg_file_sb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the reg_file_sb register file.
package reg_file_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 16;

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    // Symbolic register indices for the 16-entry default file.
    localparam logic [3:0] RX  = 4'd0;
    localparam logic [3:0] R1  = 4'd1;
    localparam logic [3:0] R2  = 4'd2;
    localparam logic [3:0] R3  = 4'd3;
    localparam logic [3:0] R4  = 4'd4;
    localparam logic [3:0] R5  = 4'd5;
    localparam logic [3:0] R6  = 4'd6;
    localparam logic [3:0] R7  = 4'd7;
    localparam logic [3:0] R8  = 4'd8;
    localparam logic [3:0] R9  = 4'd9;
    localparam logic [3:0] R10 = 4'd10;
    localparam logic [3:0] R11 = 4'd11;
    localparam logic [3:0] R12 = 4'd12;
    localparam logic [3:0] R13 = 4'd13;
    localparam logic [3:0] R14 = 4'd14;
    localparam logic [3:0] RM  = 4'd15;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Scoreboard of outstanding loads: one busy bit per register.
// mark (load issued) beats ld (load returned) on the same register; the clear
// engine zeroes one bit per cycle and blocks all other updates meanwhile.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mark_en,
    input  logic [ADDR_W-1:0]   mark_addr,
    input  logic                ld_en,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic                clr_active,
    input  logic [ADDR_W-1:0]   clr_idx,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [NUM_REGS-1:0] busy_q;

    // Busy bits: clear-engine zeroing, else ld clears then mark sets (mark wins).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else if (clr_active) begin
            busy_q[clr_idx] <= 1'b0;
        end else begin
            if (ld_en) begin
                busy_q[ld_addr] <= 1'b0;
            end
            if (mark_en) begin
                busy_q[mark_addr] <= 1'b1;
            end
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-write-port register file with load scoreboard and sequenced soft clear.
// Optional macro WRITE_BYPASS_EN forwards same-cycle write data and load
// completion onto the read ports (suppressed while clearing).
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                ld_en,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic                mark_en,
    input  logic [ADDR_W-1:0]   mark_addr,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    output logic                rd_busy1,
    output logic                rd_busy2,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic [NUM_REGS-1:0] busy_vec
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    clr_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   clr_idx_q;
    logic                clr_active;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    // Clear FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear FSM next state: clr_req only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_req) state_d = CLEAR;
            CLEAR:   if (clr_idx_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Clear FSM outputs.
    always_comb begin
        clr_active = (state_q == CLEAR);
        clr_busy   = clr_active;
    end

    // Clear index walks 0..NUM_REGS-1 and parks at 0 for the next sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_idx_q <= '0;
        end else if (clr_active) begin
            clr_idx_q <= (clr_idx_q == LAST_IDX) ? '0 : clr_idx_q + 1'b1;
        end
    end

    // Data array: port B first, port A last so A wins on an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_active) begin
            regs[clr_idx_q] <= '0;
        end else begin
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    reg_file_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .mark_en    (mark_en),
        .mark_addr  (mark_addr),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .clr_active (clr_active),
        .clr_idx    (clr_idx_q),
        .busy_vec   (busy_vec)
    );

    // Read ports: registered state, optionally overridden by same-cycle writes.
    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
        rd_busy1 = busy_vec[rd_addr1];
        rd_busy2 = busy_vec[rd_addr2];
`ifdef WRITE_BYPASS_EN
        if (!clr_active) begin
            if (wr_en && (wr_addr == rd_addr1)) begin
                rd_data1 = wr_data;
            end else if (ld_en && (ld_addr == rd_addr1)) begin
                rd_data1 = ld_data;
            end
            if (wr_en && (wr_addr == rd_addr2)) begin
                rd_data2 = wr_data;
            end else if (ld_en && (ld_addr == rd_addr2)) begin
                rd_data2 = ld_data;
            end
            // A returning load frees the register unless it is re-marked this cycle.
            if (ld_en && (ld_addr == rd_addr1) && !(mark_en && (mark_addr == rd_addr1))) begin
                rd_busy1 = 1'b0;
            end
            if (ld_en && (ld_addr == rd_addr2) && !(mark_en && (mark_addr == rd_addr2))) begin
                rd_busy2 = 1'b0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed steps followed by random traffic,
// all checked against an array-based reference model.
module tb_reg_file_sb;

    localparam int DW = 8;
    localparam int NR = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en, ld_en, mark_en, clr_req;
    logic [AW-1:0] wr_addr, ld_addr, mark_addr, rd_addr1, rd_addr2;
    logic [DW-1:0] wr_data, ld_data;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          rd_busy1, rd_busy2, clr_busy;
    logic [NR-1:0] busy_vec;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .mark_en   (mark_en),
        .mark_addr (mark_addr),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_busy1  (rd_busy1),
        .rd_busy2  (rd_busy2),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .busy_vec  (busy_vec)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: register contents, busy bits, and clear progress.
    logic [DW-1:0] m_mem [NR];
    logic [NR-1:0] m_busy;
    bit            m_clr;
    int            m_pos;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_mem[i] = '0;
        m_busy = '0;
        m_clr  = 1'b0;
        m_pos  = 0;
    endtask

    // Apply the inputs present at a rising edge to the model.
    task automatic model_edge();
        if (m_clr) begin
            m_mem[m_pos]  = '0;
            m_busy[m_pos] = 1'b0;
            m_pos++;
            if (m_pos == NR) m_clr = 1'b0;
        end else begin
            if (ld_en) begin
                m_mem[ld_addr]  = ld_data;
                m_busy[ld_addr] = 1'b0;
            end
            if (wr_en) m_mem[wr_addr] = wr_data;
            if (mark_en) m_busy[mark_addr] = 1'b1;
            if (clr_req) begin
                m_clr = 1'b1;
                m_pos = 0;
            end
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
`ifdef WRITE_BYPASS_EN
        if (!m_clr) begin
            if (wr_en && wr_addr == a) return wr_data;
            if (ld_en && ld_addr == a) return ld_data;
        end
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef WRITE_BYPASS_EN
        if (!m_clr && ld_en && ld_addr == a && !(mark_en && mark_addr == a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic idle_inputs();
        wr_en   = 1'b0;
        ld_en   = 1'b0;
        mark_en = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        idle_inputs();
    endtask

    task automatic check_reads(input string tag);
        #1;
        check({tag, "_rd1"}, 32'(rd_data1), 32'(exp_rd(rd_addr1)));
        check({tag, "_rd2"}, 32'(rd_data2), 32'(exp_rd(rd_addr2)));
        check({tag, "_bsy1"}, 32'(rd_busy1), 32'(exp_busy(rd_addr1)));
        check({tag, "_bsy2"}, 32'(rd_busy2), 32'(exp_busy(rd_addr2)));
        check({tag, "_clrb"}, 32'(clr_busy), 32'(m_clr));
        check({tag, "_bvec"}, 32'(busy_vec), 32'(m_busy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] bypass_exp;
        int cnt;

        reset = 1'b1;
        idle_inputs();
        wr_addr = '0; wr_data = '0; ld_addr = '0; ld_data = '0;
        mark_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        rd_addr1 = 4'd0; rd_addr2 = 4'd15;
        #1;
        check("rst_rd1", 32'(rd_data1), 32'h00);
        check("rst_rd2", 32'(rd_data2), 32'h00);
        check("rst_bvec", 32'(busy_vec), 32'h0000);
        check("rst_clrb", 32'(clr_busy), 32'h0);

        // Port collision: A wins.
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hAA;
        ld_en = 1'b1; ld_addr = 4'd3; ld_data = 8'h55;
        tick();
        rd_addr1 = 4'd3;
        #1 check("collide_a_wins", 32'(rd_data1), 32'hAA);

        // Mark, then mark+ld on the same register in one cycle.
        mark_en = 1'b1; mark_addr = 4'd5;
        tick();
        rd_addr1 = 4'd5;
        #1 check("mark_busy", 32'(rd_busy1), 32'h1);
        mark_en = 1'b1; mark_addr = 4'd5;
        ld_en = 1'b1; ld_addr = 4'd5; ld_data = 8'h77;
        tick();
        #1;
        check("mark_ld_busy", 32'(rd_busy1), 32'h1);
        check("mark_ld_data", 32'(rd_data1), 32'h77);

        // Fill, mark, then soft clear with a dropped mid-clear write.
        for (int i = 0; i < NR; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(8'h10 + i);
            tick();
        end
        rd_addr1 = 4'd9; rd_addr2 = 4'd14;
        check_reads("fill");
        mark_en = 1'b1; mark_addr = 4'd2;
        tick();
        clr_req = 1'b1;
        tick();
        cnt = 0;
        for (int c = 0; c < 40 && clr_busy; c++) begin
            cnt++;
            if (c == 5) begin
                wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'hFF;
            end
            rd_addr1 = AW'(c); rd_addr2 = 4'd7;
            check_reads("clr");
            tick();
        end
        check("clr_len", 32'(cnt), 32'd16);
        for (int i = 0; i < NR; i++) begin
            rd_addr1 = AW'(i);
            #1 check("post_clr_zero", 32'(rd_data1), 32'h00);
        end
        check("post_clr_bvec", 32'(busy_vec), 32'h0000);

        // Reset during clear.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(8'hA0 + i);
            tick();
        end
        clr_req = 1'b1;
        tick();
        repeat (4) tick();
        #2 reset = 1'b1;
        model_reset();
        #1 check("rst_mid_clrb", 32'(clr_busy), 32'h0);
        for (int i = 0; i < NR; i++) begin
            rd_addr1 = AW'(i);
            #1 check("rst_mid_zero", 32'(rd_data1), 32'h00);
        end
        @(negedge clk) reset = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h3C;
        tick();
        rd_addr1 = 4'd1;
        #1 check("post_rst_wr", 32'(rd_data1), 32'h3C);

        // Same-cycle read of a register being written.
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h11;
        tick();
`ifdef WRITE_BYPASS_EN
        bypass_exp = 8'h99;
`else
        bypass_exp = 8'h11;
`endif
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h99; rd_addr2 = 4'd4;
        #1 check("bypass_rd2", 32'(rd_data2), 32'(bypass_exp));
        tick();
        #1 check("after_wr_rd2", 32'(rd_data2), 32'h99);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = AW'($urandom);
            wr_data   = DW'($urandom);
            ld_en     = 1'($urandom_range(0, 1));
            ld_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            ld_data   = DW'($urandom);
            mark_en   = 1'($urandom_range(0, 1));
            mark_addr = ($urandom_range(0, 3) == 0) ? ld_addr : AW'($urandom);
            clr_req   = ($urandom_range(0, 39) == 0);
            rd_addr1  = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom);
            rd_addr2  = ($urandom_range(0, 2) == 0) ? ld_addr : AW'($urandom);
            check_reads("rand");
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
